pll_reset_ctrl: RTL and testbench

PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

---
 rtl/pll_reset_ctrl.sv | 123 ++++++++++++
 tb/tb_pll_reset_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a synchronized lock,
// requires a stable lock window, then releases the downstream system reset.
module pll_reset_ctrl #(
  parameter int unsigned RESET_CYCLES        = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pll_locked,
  output logic       o_pll_rst,
  output logic       o_rst,
  output logic       o_ready,
  output logic [7:0] o_timeout_count,
  output logic [7:0] o_lock_loss_count
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned STAT_W = 8;

  localparam logic [1:0] RESET_PLL = 2'd0;
  localparam logic [1:0] WAIT_LOCK = 2'd1;
  localparam logic [1:0] STABILIZE = 2'd2;
  localparam logic [1:0] RUNNING   = 2'd3;

  localparam logic [CNT_W-1:0]  RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [STAT_W-1:0] STAT_MAX     = '1;

  logic              sync_q;
  logic              locked_s;
  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              timeout_hit;
  logic              loss_hit;

  // Two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= i_pll_locked;
      locked_s <= sync_q;
    end
  end

  // State, cycle counter, status counters; outputs registered from next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state             <= RESET_PLL;
      cnt               <= '0;
      o_timeout_count   <= '0;
      o_lock_loss_count <= '0;
      o_pll_rst         <= 1'b1;
      o_rst             <= 1'b1;
      o_ready           <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      o_pll_rst <= (state_next == RESET_PLL);
      o_rst     <= (state_next != RUNNING);
      o_ready   <= (state_next == RUNNING);
      if (timeout_hit && (o_timeout_count != STAT_MAX)) begin
        o_timeout_count <= o_timeout_count + STAT_W'(1);
      end
      if (loss_hit && (o_lock_loss_count != STAT_MAX)) begin
        o_lock_loss_count <= o_lock_loss_count + STAT_W'(1);
      end
    end
  end

  // Next-state logic; the counter clears on every transition
  always_comb begin
    state_next  = state;
    cnt_next    = cnt + CNT_W'(1);
    timeout_hit = 1'b0;
    loss_hit    = 1'b0;
    case (state)
      RESET_PLL: begin
        if (cnt == RESET_LAST) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout
        if (locked_s) begin
          state_next = STABILIZE;
          cnt_next   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next  = RESET_PLL;
          cnt_next    = '0;
          timeout_hit = 1'b1;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_next = RUNNING;
          cnt_next   = '0;
        end
      end
      RUNNING: begin
        cnt_next = '0;
        if (!locked_s) begin
          state_next = RESET_PLL;
          loss_hit   = 1'b1;
        end
      end
      default: begin
        state_next = RESET_PLL;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl with short timing parameters.
module tb_pll_reset_ctrl;

  typedef struct packed {
    logic       pll_rst;
    logic       rst;
    logic       ready;
    logic [7:0] tc;
    logic [7:0] llc;
  } out_t;

  typedef struct {
    string name;
    logic  rst;
    logic  locked;
    int    n;
    out_t  exp;
  } seg_t;

  logic       i_clk;
  logic       i_rst;
  logic       i_pll_locked;
  logic       o_pll_rst;
  logic       o_rst;
  logic       o_ready;
  logic [7:0] o_timeout_count;
  logic [7:0] o_lock_loss_count;

  int   n_checks;
  int   n_fail;
  out_t exp_q[$];
  seg_t segs[$];

  pll_reset_ctrl #(
    .RESET_CYCLES       (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES (8)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_pll_locked     (i_pll_locked),
    .o_pll_rst        (o_pll_rst),
    .o_rst            (o_rst),
    .o_ready          (o_ready),
    .o_timeout_count  (o_timeout_count),
    .o_lock_loss_count(o_lock_loss_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic out_t rp(input int tc, input int llc);
    return {1'b1, 1'b1, 1'b0, 8'(tc), 8'(llc)};
  endfunction

  function automatic out_t wt(input int tc, input int llc);
    return {1'b0, 1'b1, 1'b0, 8'(tc), 8'(llc)};
  endfunction

  function automatic out_t rn(input int tc, input int llc);
    return {1'b0, 1'b0, 1'b1, 8'(tc), 8'(llc)};
  endfunction

  function automatic void add(input string name, input logic r, input logic lk,
                              input int n, input out_t e);
    seg_t s;
    s.name = name; s.rst = r; s.locked = lk; s.n = n; s.exp = e;
    segs.push_back(s);
  endfunction

  // Drive one cycle, queue its expectation, compare after the edge
  task automatic step(input string name, input logic r, input logic lk, input out_t e);
    out_t act;
    out_t want;
    i_rst        = r;
    i_pll_locked = lk;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    act  = {o_pll_rst, o_rst, o_ready, o_timeout_count, o_lock_loss_count};
    want = exp_q.pop_front();
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got pll_rst=%b rst=%b ready=%b tc=%0d llc=%0d want pll_rst=%b rst=%b ready=%b tc=%0d llc=%0d",
               name, $time, act.pll_rst, act.rst, act.ready, act.tc, act.llc,
               want.pll_rst, want.rst, want.ready, want.tc, want.llc);
    end
  endtask

  task automatic run_seg(input string name, input logic r, input logic lk,
                         input int n, input out_t e);
    for (int i = 0; i < n; i++) step(name, r, lk, e);
  endtask

  initial begin
    int llc;
    n_checks     = 0;
    n_fail       = 0;
    i_rst        = 1'b1;
    i_pll_locked = 1'b0;

    // Normal lock
    add("reset_state",    1, 0, 2,  rp(0, 0));
    add("pll_rst_pulse",  0, 0, 3,  rp(0, 0));
    add("wait_no_lock",   0, 0, 5,  wt(0, 0));
    add("sync_and_stab",  0, 1, 10, wt(0, 0));
    add("running",        0, 1, 5,  rn(0, 0));
    // Lock loss then a one-cycle glitch in STABILIZE
    add("loss_latency",   0, 0, 2,  rn(0, 0));
    add("loss_reset_pll", 0, 0, 4,  rp(0, 1));
    add("loss_wait",      0, 0, 3,  wt(0, 1));
    add("pre_glitch",     0, 1, 5,  wt(0, 1));
    add("glitch",         0, 0, 1,  wt(0, 1));
    add("restabilize",    0, 1, 10, wt(0, 1));
    add("relocked",       0, 1, 3,  rn(0, 1));
    // Lock never arrives
    add("to_latency",     0, 0, 2,  rn(0, 1));
    add("to_reset_pll",   0, 0, 4,  rp(0, 2));
    for (int i = 1; i <= 5; i++) begin
      add("to_wait",  0, 0, 32, wt(i - 1, 2));
      add("to_pulse", 0, 0, 4,  rp(i, 2));
    end
    add("to_recover",     0, 1, 10, wt(5, 2));
    add("to_running",     0, 1, 2,  rn(5, 2));
    // Lock arrives on the same cycle the timeout expires
    add("tie_latency",    0, 0, 2,  rn(5, 2));
    add("tie_reset_pll",  0, 0, 4,  rp(5, 3));
    add("tie_wait",       0, 0, 30, wt(5, 3));
    add("tie_lock_sync",  0, 1, 2,  wt(5, 3));
    add("tie_lock_wins",  0, 1, 8,  wt(5, 3));
    add("tie_running",    0, 1, 2,  rn(5, 3));

    foreach (segs[i]) run_seg(segs[i].name, segs[i].rst, segs[i].locked, segs[i].n, segs[i].exp);

    // Repeated single-cycle lock drops until the loss counter saturates
    llc = 3;
    for (int i = 0; i < 260; i++) begin
      int nx;
      nx = (llc == 255) ? 255 : llc + 1;
      step("sat_drop", 0, 0, rn(5, llc));
      step("sat_latency", 0, 1, rn(5, llc));
      run_seg("sat_reset_pll", 0, 1, 4, rp(5, nx));
      run_seg("sat_relock", 0, 1, 9, wt(5, nx));
      llc = nx;
    end
    run_seg("sat_hold", 0, 1, 2, rn(5, 255));

    // Synchronous reset mid-RUNNING clears everything; RESET_PLL ignores lock
    step("rst_in_running", 1, 1, rp(0, 0));
    run_seg("rst_release", 0, 1, 3, rp(0, 0));
    run_seg("rst_relock", 0, 1, 9, wt(0, 0));
    run_seg("rst_running", 0, 1, 2, rn(0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
